// File: rtl/fpadd_pkg.sv
// Shared definitions for the sequenced single-precision adder: state encoding,
// field widths and the canned special results.
package fpadd_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 27;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMP   = 3'd1,
    S_ALIGN = 3'd2,
    S_ADD   = 3'd3,
    S_NORM  = 3'd4,
    S_ROUND = 3'd5,
    S_DONE  = 3'd6
  } state_t;
endpackage

// File: rtl/fpadd_seq_if.sv
// Operand/result handshake bundle for fpadd_seq (issue side master, adder slave).
interface fpadd_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        busy;

  modport slave  (input  in_valid, a, b, sub, out_ready,
                  output in_ready, out_valid, res, busy);
  modport master (output in_valid, a, b, sub, out_ready,
                  input  in_ready, out_valid, res, busy);
endinterface

// File: rtl/fpadd_lzc.sv
// 28-bit leading-zero counter (28 when the input is all zero); used by the
// single-cycle normalizer.
module fpadd_lzc (
  input  logic [27:0] x_i,
  output logic [4:0]  cnt_o
);
  always_comb begin
    cnt_o = 5'd28;
    for (int i = 0; i < 28; i++)
      if (x_i[i]) cnt_o = 5'(27 - i);
  end
endmodule

// File: rtl/fpadd_seq.sv
// Multi-cycle IEEE-754 single add/sub sequencer, one op in flight.
// FPADD_FAST_NORM_EN: single-cycle LZC/barrel normalize instead of 1-bit steps.
module fpadd_seq
  import fpadd_pkg::*;
#(
  parameter int SAT_SHIFT = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  fpadd_seq_if.slave  io
);
  localparam logic [7:0] SAT8 = 8'(SAT_SHIFT);

  state_t              state_q;
  logic [31:0]         a_q, b_q, res_q;
  logic                sign_q, esub_q, in_ready_q, out_valid_q, busy_q;
  logic [9:0]          exp_q;
  logic [7:0]          d_q;
  logic [MANT_W-1:0]   ml_q, ms_q;
  logic [MANT_W:0]     sum_q;

  // Compare/swap; exp==0 operands are flushed to zero before ordering
  logic [EXP_W-1:0]  ea, eb, el, es;
  logic [FRAC_W-1:0] fa, fb, fl, fs;
  logic              a_nan, b_nan, a_inf, b_inf, a_ge, sl, spec;
  assign ea    = a_q[30:23];
  assign eb    = b_q[30:23];
  assign fa    = (ea == '0) ? '0 : a_q[22:0];
  assign fb    = (eb == '0) ? '0 : b_q[22:0];
  assign a_nan = (&ea) & (|fa);
  assign b_nan = (&eb) & (|fb);
  assign a_inf = (&ea) & ~(|fa);
  assign b_inf = (&eb) & ~(|fb);
  assign a_ge  = {ea, fa} >= {eb, fb};
  assign el    = a_ge ? ea : eb;
  assign es    = a_ge ? eb : ea;
  assign fl    = a_ge ? fa : fb;
  assign fs    = a_ge ? fb : fa;
  assign sl    = a_ge ? a_q[31] : b_q[31];
  assign spec  = a_nan | b_nan | a_inf | b_inf;

  logic [7:0]          sh;
  logic [2*MANT_W-1:0] al;
  assign sh = (d_q >= SAT8) ? SAT8 : d_q;
  assign al = {ms_q, {MANT_W{1'b0}}} >> sh;

  // Round-to-nearest-even on G/R/S; mr[24] is the renormalizing carry
  logic        rnd_up;
  logic [24:0] mr;
  logic [9:0]  er;
  assign rnd_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
  assign mr     = {1'b0, sum_q[26:3]} + {24'b0, rnd_up};
  assign er     = exp_q + {9'b0, mr[24]};

`ifdef FPADD_FAST_NORM_EN
  logic [4:0] lz, lsh;
  fpadd_lzc u_lzc (.x_i(sum_q), .cnt_o(lz));
  assign lsh = lz - 5'd1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  a_q <= '0;  b_q <= '0;  res_q <= '0;
      sign_q <= 1'b0;  esub_q <= 1'b0;  exp_q <= '0;  d_q <= '0;
      ml_q <= '0;  ms_q <= '0;  sum_q <= '0;
      in_ready_q <= 1'b1;  out_valid_q <= 1'b0;  busy_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (io.in_valid) begin
          a_q        <= io.a;
          b_q        <= {io.b[31] ^ io.sub, io.b[30:0]};
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= S_CMP;
        end
        S_CMP: begin
          if (spec) begin
            if (a_nan | b_nan | (a_inf & b_inf & (a_q[31] ^ b_q[31]))) res_q <= QNAN;
            else if (a_inf) res_q <= {a_q[31], PINF[30:0]};
            else            res_q <= {b_q[31], PINF[30:0]};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            sign_q  <= sl;
            esub_q  <= a_q[31] ^ b_q[31];
            exp_q   <= {2'b0, el};
            d_q     <= el - es;
            ml_q    <= {el != '0, fl, 3'b0};
            ms_q    <= {es != '0, fs, 3'b0};
            state_q <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          ms_q    <= {al[2*MANT_W-1:MANT_W+1], al[MANT_W] | (|al[MANT_W-1:0])};
          state_q <= S_ADD;
        end
        S_ADD: begin
          sum_q   <= esub_q ? {1'b0, ml_q} - {1'b0, ms_q} : {1'b0, ml_q} + {1'b0, ms_q};
          state_q <= S_NORM;
        end
        S_NORM: begin
          if (sum_q == '0) begin
            sign_q  <= 1'b0;
            exp_q   <= '0;
            state_q <= S_ROUND;
          end else if (sum_q[27]) begin
            sum_q   <= {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
            exp_q   <= exp_q + 10'd1;
            state_q <= S_ROUND;
`ifdef FPADD_FAST_NORM_EN
          end else if ({5'b0, lsh} <= exp_q - 10'd1) begin
            sum_q   <= sum_q << lsh;
            exp_q   <= exp_q - {5'b0, lsh};
            state_q <= S_ROUND;
          end else begin
            sum_q   <= '0;
            exp_q   <= '0;
            state_q <= S_ROUND;
          end
`else
          end else if (sum_q[26]) begin
            state_q <= S_ROUND;
          end else if (exp_q == 10'd1) begin
            sum_q   <= '0;
            exp_q   <= '0;
            state_q <= S_ROUND;
          end else begin
            sum_q   <= sum_q << 1;
            exp_q   <= exp_q - 10'd1;
          end
`endif
        end
        S_ROUND: begin
          // A zero sum here is either an exact zero or an underflow flush
          if (sum_q == '0)          res_q <= {sign_q, 31'b0};
          else if (er >= 10'd255)   res_q <= {sign_q, PINF[30:0]};
          else                      res_q <= {sign_q, er[7:0], mr[22:0]};
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: if (io.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.res       = res_q;
  assign io.busy      = busy_q;
endmodule

// File: tb/tb_fpadd_seq.sv
// Bench for fpadd_seq: exact wide-integer reference sum with RNE/FTZ, per-cycle
// handshake/latency/result checker, directed literals plus randomized traffic.
module tb_fpadd_seq;
  logic clk = 1'b0;
  logic rst_n;
  fpadd_seq_if bus();

  fpadd_seq #(.SAT_SHIFT(27)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

  initial forever #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int done_cnt = 0, obs_lat = 0;
  logic [31:0] obs_res = '0;

`ifdef FPADD_FAST_NORM_EN
  localparam int LAT_C2 = 6;
`else
  localparam int LAT_C2 = 8;
`endif

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp_v, $time);
    end
  endtask

  // Reference: operands as exact integers scaled by 2^150, exact sum, then
  // flush-below-normal and round-to-nearest-even to 24 significant bits.
  function automatic logic [31:0] model_res(input logic [31:0] x, input logic [31:0] y0,
                                            input logic s, output int lat);
    logic [31:0]  y;
    logic [299:0] va, vb, mag, keep, rem, half, one;
    logic sx, sy, sg;
    int ex, ey, el, p, e, sh;
    y  = y0 ^ {s, 31'b0};
    sx = x[31];  sy = y[31];
    ex = int'(x[30:23]);  ey = int'(y[30:23]);
    lat = 2;
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0) ||
        (ex == 255 && ey == 255 && sx != sy)) return 32'h7FC00000;
    if (ex == 255) return {sx, 8'hFF, 23'h0};
    if (ey == 255) return {sy, 8'hFF, 23'h0};
    va = (ex == 0) ? '0 : (300'({1'b1, x[22:0]}) << ex);
    vb = (ey == 0) ? '0 : (300'({1'b1, y[22:0]}) << ey);
    if (sx == sy)      begin mag = va + vb; sg = sx; end
    else if (va >= vb) begin mag = va - vb; sg = sx; end
    else               begin mag = vb - va; sg = sy; end
    lat = 6;
    if (mag == '0) return 32'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e  = p - 23;
    el = (ex > ey) ? ex : ey;
`ifndef FPADD_FAST_NORM_EN
    if (e < el) lat = 6 + ((e >= 1) ? el - e : el - 1);
`endif
    if (e < 1) return {sg, 31'h0};
    sh   = p - 23;
    one  = 300'd1;
    keep = mag >> sh;
    rem  = mag & ((one << sh) - one);
    half = one << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + one;
    if (keep[24]) begin keep = keep >> 1; e++; end
    if (e >= 255) return {sg, 8'hFF, 23'h0};
    return {sg, e[7:0], keep[22:0]};
  endfunction

  // Per-cycle checker: tracks the single in-flight op from the observed accept.
  bit          pend = 0;
  int          acc_cyc = 0, e_lat = 0, fov = -1;
  logic [31:0] e_res = '0;
  initial forever @(posedge clk) cyc++;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_res",       bus.res,            32'd0);
      pend = 0;
    end else begin
      bit ov_e;
      chk("busy",     32'(bus.busy),     32'(pend));
      chk("in_ready", 32'(bus.in_ready), 32'(!pend));
      ov_e = pend && (cyc >= acc_cyc + e_lat);
      chk("out_valid", 32'(bus.out_valid), 32'(ov_e));
      if (ov_e) chk("res", bus.res, e_res);
      if (pend && bus.out_valid && fov < 0) fov = cyc;
      if (pend && bus.out_valid && bus.out_ready) begin
        pend = 0;  obs_res = bus.res;  obs_lat = fov - acc_cyc;  done_cnt++;
      end else if (!pend && bus.in_valid && bus.in_ready) begin
        pend = 1;  acc_cyc = cyc;  fov = -1;
        e_res = model_res(bus.a, bus.b, bus.sub, e_lat);
      end
    end
  end

  task automatic dir_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic ts, input logic [31:0] er, input int el);
    int d0, k, ml;
    logic [31:0] mr;
    d0 = done_cnt;
    bus.a = ta;  bus.b = tb_;  bus.sub = ts;  bus.in_valid = 1'b1;  bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 80) begin @(posedge clk); #1; k++; end
    chk({nm, "_done"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, "_res"},  obs_res, er);
    chk({nm, "_lat"},  32'(obs_lat), 32'(el));
    mr = model_res(ta, tb_, ts, ml);
    chk({nm, "_model_res"}, mr, er);
    chk({nm, "_model_lat"}, 32'(ml), 32'(el));
  endtask

  function automatic logic [31:0] rnd_fp(input logic [7:0] near);
    logic [31:0] x;
    int c;
    x = $urandom;
    c = $urandom_range(0, 19);
    if (c == 0)      x[30:23] = 8'hFF;
    else if (c == 1) begin x[30:23] = 8'hFF; x[22:0] = '0; end
    else if (c == 2) x[30:23] = 8'h00;
    else if (c < 14) x[30:23] = near + 8'($urandom_range(0, 4)) - 8'd2;
    if (c == 3) x[22:0] = '0;
    return x;
  endfunction

  initial begin
    int d0, k;
    logic [7:0] pick;
    bus.in_valid = 1'b0;  bus.a = '0;  bus.b = '0;  bus.sub = 1'b0;  bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    dir_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 6);
    dir_op("ovf_inf",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 6);
    dir_op("cancel_norm",  32'h3F800000, 32'hBF400000, 1'b0, 32'h3E800000, LAT_C2);
    dir_op("tie_even",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 6);
    dir_op("tie_up",       32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 6);
    dir_op("inf_minf",     32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2);
    dir_op("nan_in",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 2);
    dir_op("x_minus_x",    32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 6);
    dir_op("denorm_ftz",   32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 6);
    dir_op("sub_inf",      32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 2);

    // Backpressure: result held, new operands ignored while busy
    bus.a = 32'h3F800000;  bus.b = 32'h3F800000;  bus.sub = 1'b0;
    bus.out_ready = 1'b0;  bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 32'h12345678;
    repeat (16) @(posedge clk); #1;
    chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
    chk("hold_res",       bus.res,            32'h40000000);
    chk("hold_in_ready",  32'(bus.in_ready),  32'd0);
    d0 = done_cnt;
    bus.in_valid = 1'b0;  bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", 32'(done_cnt - d0), 32'd1);
    @(posedge clk); #1;

    // Reset while the op sits in NORM
    bus.a = 32'h3F800000;  bus.b = 32'hBF400000;  bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("midrst_busy",      32'(bus.busy),      32'd0);
    chk("midrst_res",       bus.res,            32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    dir_op("post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 6);

    // Random traffic; the checker models whatever it sees accepted
    for (int i = 0; i < 5000; i++) begin
      case ($urandom_range(0, 3))
        0:       pick = 8'd1;
        1:       pick = 8'd254;
        default: pick = 8'($urandom);
      endcase
      bus.a = rnd_fp(pick);
      bus.b = rnd_fp(bus.a[30:23]);
      if ($urandom_range(0, 7) == 0) bus.b = bus.a ^ 32'($urandom_range(0, 15));
      bus.sub       = 1'($urandom_range(0, 1));
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;  bus.out_ready = 1'b1;
    k = 0;
    while (pend && k < 100) begin @(posedge clk); #1; k++; end
    chk("drain_idle", 32'(pend), 32'd0);
    chk("done_count_min", 32'(done_cnt > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
